// File: rtl/sort_engine_arbiter_pkg.sv
// sort_arb_pkg: shared types and helpers for the sort engine arbiter.
//   arb_state_t : arbiter FSM states
//   rr_pick     : round-robin one-hot pick over up to MAX_REQ requesters
// Optional feature macro used by this slice: SORT_ARB_TRUNC_ERR_EN
package sort_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        DRAIN
    } arb_state_t;

    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_REQ_W = 5;

    // First set bit of req at or after ptr, wrapping at n; one-hot result.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        logic [31:0]        idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[MAX_REQ_W-1:0]]) begin
                    gnt[idx[MAX_REQ_W-1:0]] = 1'b1;
                    found                   = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/sort_engine_arbiter_if.sv
// sort_engine_arbiter_if: all stream/engine signals of the arbiter.
//   in_*      : NUM_REQ ingress Avalon-ST sources (data packed per source)
//   eng_*     : sort engine write/control port and its sorted output stream
//   out_*     : tagged sorted stream towards downstream, busy_o status
// Modports: master = arbiter side, slave = surrounding environment.
interface sort_engine_arbiter_if #(
    parameter  int unsigned NUM_REQ = 2,
    parameter  int unsigned DWIDTH  = 8,
    localparam int unsigned TAG_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]             in_valid_i;
    logic [NUM_REQ-1:0]             in_sop_i;
    logic [NUM_REQ-1:0]             in_eop_i;
    logic [NUM_REQ-1:0][DWIDTH-1:0] in_data_i;
    logic [NUM_REQ-1:0]             in_ready_o;

    logic                           eng_srst_o;
    logic                           eng_run_o;
    logic                           eng_wr_req_o;
    logic [DWIDTH-1:0]              eng_wr_data_o;
    logic [DWIDTH-1:0]              eng_out_data_i;
    logic                           eng_out_valid_i;
    logic                           eng_out_sop_i;
    logic                           eng_out_eop_i;
    logic                           eng_out_ready_o;

    logic [DWIDTH-1:0]              out_data_o;
    logic                           out_valid_o;
    logic                           out_sop_o;
    logic                           out_eop_o;
    logic                           out_ready_i;
    logic [TAG_W-1:0]               out_tag_o;
    logic                           out_err_o;
    logic                           busy_o;

    modport master (
        input  in_valid_i, in_sop_i, in_eop_i, in_data_i,
        output in_ready_o,
        output eng_srst_o, eng_run_o, eng_wr_req_o, eng_wr_data_o,
        input  eng_out_data_i, eng_out_valid_i, eng_out_sop_i, eng_out_eop_i,
        output eng_out_ready_o,
        output out_data_o, out_valid_o, out_sop_o, out_eop_o,
        input  out_ready_i,
        output out_tag_o, out_err_o, busy_o
    );

    modport slave (
        output in_valid_i, in_sop_i, in_eop_i, in_data_i,
        input  in_ready_o,
        input  eng_srst_o, eng_run_o, eng_wr_req_o, eng_wr_data_o,
        output eng_out_data_i, eng_out_valid_i, eng_out_sop_i, eng_out_eop_i,
        input  eng_out_ready_o,
        input  out_data_o, out_valid_o, out_sop_o, out_eop_o,
        output out_ready_i,
        input  out_tag_o, out_err_o, busy_o
    );
endinterface

// File: rtl/sort_engine_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       : request vector (one bit per source)
//   ptr       : highest-priority index this round
//   gnt       : one-hot grant
//   gnt_valid : at least one request present
module rr_arbiter
    import sort_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned TAG_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid
);
    logic [MAX_REQ-1:0] pick;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req), 32'(ptr), NUM_REQ);
        gnt       = pick[NUM_REQ-1:0];
        gnt_valid = |gnt;
    end
endmodule

// File: rtl/sort_engine_arbiter.sv
// sort_engine_arbiter: shares one sort engine between NUM_REQ packet sources.
// One packet = one sort job: round-robin grant, clear engine, stream words in,
// strobe run, then pass the sorted stream through tagged with the source index.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : sort_engine_arbiter_if.master (ingress, engine, egress)
// Optional feature: define SORT_ARB_TRUNC_ERR_EN to flag oversize jobs on
// out_err_o at eop; otherwise out_err_o is 0 and excess words drop silently.
module sort_engine_arbiter
    import sort_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    parameter  int unsigned AWIDTH  = 5,
    parameter  int unsigned DWIDTH  = 8,
    localparam int unsigned TAG_W   = $clog2(NUM_REQ)
) (
    input logic                  clk_i,
    input logic                  rst_i,
    sort_engine_arbiter_if.master bus
);
    arb_state_t         state;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   g;
    logic [TAG_W-1:0]   next_ptr;
    logic [AWIDTH:0]    wcnt;
    logic               srst;
    logic               run;
    logic               busy;
    logic [TAG_W-1:0]   tag;
`ifdef SORT_ARB_TRUNC_ERR_EN
    logic               trunc;
`endif

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [TAG_W-1:0]   gnt_idx;
    logic               accept;
    logic               room;
    logic               drain;
    logic               out_fire;

    assign cand = bus.in_valid_i & bus.in_sop_i;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (cand),
        .ptr       (rr_ptr),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) gnt_idx = TAG_W'(k);
        end
    end

    // Top bit of wcnt set means the engine already holds 2^AWIDTH words.
    assign room     = ~wcnt[AWIDTH];
    assign accept   = (state == LOAD) && bus.in_valid_i[g] && !rst_i;
    assign drain    = (state == DRAIN);
    assign out_fire = drain && bus.eng_out_valid_i && bus.out_ready_i && bus.eng_out_eop_i;
    assign next_ptr = (g == TAG_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;

    always_comb begin
        bus.in_ready_o = '0;
        if (!rst_i) begin
            case (state)
                // Stray non-sop words are swallowed so a source can resync.
                IDLE:    bus.in_ready_o = bus.in_valid_i & ~bus.in_sop_i;
                LOAD:    bus.in_ready_o[g] = 1'b1;
                default: bus.in_ready_o = '0;
            endcase
        end
    end

    always_comb begin
        bus.eng_wr_req_o    = accept && room;
        bus.eng_wr_data_o   = (accept && room) ? bus.in_data_i[g] : '0;
        bus.eng_srst_o      = srst;
        bus.eng_run_o       = run;
        bus.eng_out_ready_o = drain && bus.out_ready_i;
        bus.out_valid_o     = drain && bus.eng_out_valid_i;
        bus.out_sop_o       = drain && bus.eng_out_sop_i;
        bus.out_eop_o       = drain && bus.eng_out_eop_i;
        bus.out_data_o      = drain ? bus.eng_out_data_i : '0;
        bus.out_tag_o       = tag;
        bus.busy_o          = busy;
`ifdef SORT_ARB_TRUNC_ERR_EN
        bus.out_err_o       = trunc && drain && bus.eng_out_eop_i;
`else
        bus.out_err_o       = 1'b0;
`endif
    end

    // srst/run/busy/tag are registered alongside the state transition so they
    // line up exactly with CLEAR, RUN and state != IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            g      <= '0;
            wcnt   <= '0;
            srst   <= 1'b0;
            run    <= 1'b0;
            busy   <= 1'b0;
            tag    <= '0;
`ifdef SORT_ARB_TRUNC_ERR_EN
            trunc  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        g     <= gnt_idx;
                        tag   <= gnt_idx;
                        srst  <= 1'b1;
                        busy  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    srst  <= 1'b0;
                    wcnt  <= '0;
`ifdef SORT_ARB_TRUNC_ERR_EN
                    trunc <= 1'b0;
`endif
                    state <= LOAD;
                end
                LOAD: begin
                    if (accept) begin
                        if (room) wcnt <= wcnt + 1'b1;
`ifdef SORT_ARB_TRUNC_ERR_EN
                        else trunc <= 1'b1;
`endif
                        if (bus.in_eop_i[g]) begin
                            run   <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    run   <= 1'b0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (out_fire) begin
                        rr_ptr <= next_ptr;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
